// File: rtl/arq_pkg.sv
// arq_pkg: shared types for the stop-and-wait ARQ controller.
// Holds the FSM state enum, the acknowledgement encoding and width helpers.
package arq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_ACK
   } arq_state_e;

   // Widest packet the acknowledgement helper handles.
   localparam int unsigned ACK_W = 64;

   // The peer answers a packet with its bitwise complement.
   function automatic logic [ACK_W-1:0] ack_of(
      input logic [ACK_W-1:0] pkt
   );
      return ~pkt;
   endfunction

   // Width of the retry counter; one bit minimum even with no retries.
   function automatic int unsigned retry_w(
      input int unsigned max_retry
   );
      return (max_retry > 0) ? $clog2(max_retry + 1) : 1;
   endfunction

endpackage

// File: rtl/arq_controller_if.sv
// arq_controller_if: application and Encoder/Decoder signals of the ARQ.
// slave = controller side, master = application plus link side.
interface arq_controller_if
   import arq_pkg::*;
#(
   parameter int unsigned N_PKT     = 8,
   parameter int unsigned MAX_RETRY = 3
);

   localparam int unsigned RW = retry_w(MAX_RETRY);

   logic [N_PKT-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             done;
   logic             fail;
   logic [RW-1:0]    retries;
   logic             start_ENC;
   logic [N_PKT-1:0] data_ENC;
   logic             avail_ENC;
   logic [N_PKT-1:0] data_DEC;
   logic             avail_DEC;
   logic             error_DEC;
   logic             read_DEC;

   modport master (
      output tx_data, tx_valid,
      output avail_ENC, data_DEC, avail_DEC, error_DEC,
      input  tx_ready, done, fail, retries,
      input  start_ENC, data_ENC, read_DEC
   );

   modport slave (
      input  tx_data, tx_valid,
      input  avail_ENC, data_DEC, avail_DEC, error_DEC,
      output tx_ready, done, fail, retries,
      output start_ENC, data_ENC, read_DEC
   );

endinterface

// File: rtl/arq_timer.sv
// arq_timer: timeout counter; clr restarts, en advances, expire flags
// the last cycle of the window. Ports: clk, rst, clr, en, expire.
module arq_timer #(
   parameter int unsigned TIMEOUT = 1540
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int unsigned TW = $clog2(TIMEOUT);

   logic [TW-1:0] count_q;

   // The clearing cycle is itself the first elapsed cycle of the window,
   // so the count restarts at one.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= TW'(1);
      end else if (en) begin
         count_q <= count_q + TW'(1);
      end
   end

   assign expire = en & (count_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/arq_controller.sv
// arq_controller: stop-and-wait retransmission over one Encoder/Decoder.
// Ports: clk, rst, bus (application handshake, Encoder start, Decoder read).
module arq_controller
   import arq_pkg::*;
#(
   parameter int unsigned N_PKT     = 8,
   parameter int unsigned TIMEOUT   = 1540,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic             clk,
   input  logic             rst,
   arq_controller_if.slave  bus
);

   localparam int unsigned RW = retry_w(MAX_RETRY);

   arq_state_e       state_q;
   logic [N_PKT-1:0] pkt_q;
   logic [RW-1:0]    retries_q;
   logic             done_q;
   logic             fail_q;
   logic             read_q;

   logic accept;
   logic start;
   logic read_dec;
   logic ack_ok;
   logic timing;
   logic expire;

   arq_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (start),
      .en     (timing),
      .expire (expire)
   );

   always_comb begin
      accept   = 1'b0;
      start    = 1'b0;
      timing   = 1'b0;
      read_dec = 1'b0;
      ack_ok   = 1'b0;
      accept   = (state_q == IDLE) & bus.tx_valid;
      start    = (state_q == SEND) & bus.avail_ENC;
      timing   = (state_q == WAIT_ACK);
      // avail_DEC drops a cycle after the read; read_q masks that echo.
      read_dec = bus.avail_DEC & ~read_q;
      ack_ok   = timing & read_dec & ~bus.error_DEC &
                 (bus.data_DEC == N_PKT'(ack_of(ACK_W'(pkt_q))));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pkt_q     <= '0;
         retries_q <= '0;
         done_q    <= 1'b0;
         fail_q    <= 1'b0;
         read_q    <= 1'b0;
      end else begin
         read_q <= read_dec;
         done_q <= 1'b0;
         fail_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  pkt_q     <= bus.tx_data;
                  retries_q <= '0;
                  state_q   <= SEND;
               end
            end
            SEND: begin
               if (start) begin
                  state_q <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               // An ack on the expiry cycle still counts.
               if (ack_ok) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else if (expire) begin
                  if (retries_q < RW'(MAX_RETRY)) begin
                     retries_q <= retries_q + RW'(1);
                     state_q   <= SEND;
                  end else begin
                     fail_q  <= 1'b1;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.tx_ready  = (state_q == IDLE);
   assign bus.start_ENC = start;
   assign bus.data_ENC  = pkt_q;
   assign bus.read_DEC  = read_dec;
   assign bus.done      = done_q;
   assign bus.fail      = fail_q;
   assign bus.retries   = retries_q;

endmodule

// File: tb/tb_arq_controller.sv
// tb_arq_controller: randomized transactions against a timing model
// of the ARQ, with a peer that echoes, drops and corrupts bytes.
`timescale 1ns/1ps
module tb_arq_controller;

   localparam int unsigned N_PKT     = 8;
   localparam int unsigned TIMEOUT   = 1540;
   localparam int unsigned MAX_RETRY = 3;

   typedef struct {
      int               at;
      logic [N_PKT-1:0] data;
      logic             err;
   } byte_t;

   logic clk = 1'b0;
   logic rst;

   arq_controller_if #(
      .N_PKT     (N_PKT),
      .MAX_RETRY (MAX_RETRY)
   ) bus ();

   arq_controller #(
      .N_PKT     (N_PKT),
      .TIMEOUT   (TIMEOUT),
      .MAX_RETRY (MAX_RETRY)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   byte_t dq[$];
   logic  dec_busy;
   int    dec_rd;
   int    enc_busy_until;

   int starts[$];
   int n_reads, n_done, n_fail, n_sched;
   int done_cyc, fail_cyc, ret_at_end;

   logic [N_PKT-1:0] t_pkt;
   int t_lost, t_d, t_busy, t_njunk;

   task automatic check(string tag, longint got, longint exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push_byte(int at, logic [N_PKT-1:0] d, logic e);
      byte_t b;
      b.at   = at;
      b.data = d;
      b.err  = e;
      dq.push_back(b);
      n_sched++;
   endtask

   // Peer behaviour for attempt k launched in cycle s.
   task automatic sched_attempt(int k, int s);
      bit ok;
      int n;
      int lim;
      int j;
      ok = (k == t_lost);
      if (t_njunk < 0) n = int'($urandom_range(0, 2));
      else n = t_njunk;
      if (ok && t_d < 3 * n + 1) n = 0;
      lim = ok ? t_d - 3 * n : int'(TIMEOUT) - 3 * n;
      if (n > 0) begin
         j = int'($urandom_range(1, lim));
         for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) push_byte(s + j + 3 * i, ~t_pkt, 1'b1);
            else push_byte(s + j + 3 * i, t_pkt, 1'b0);
         end
      end
      if (ok) push_byte(s + t_d, ~t_pkt, 1'b0);
   endtask

   task automatic drive();
      bus.avail_ENC = (cyc > enc_busy_until);
      if (dec_busy && dec_rd >= 0 && cyc > dec_rd + 1) dec_busy = 1'b0;
      if (!dec_busy) begin
         bus.data_DEC  = ~t_pkt;
         bus.error_DEC = 1'b0;
      end
      if (!dec_busy && dq.size() > 0 && dq[0].at <= cyc) begin
         bus.data_DEC  = dq[0].data;
         bus.error_DEC = dq[0].err;
         void'(dq.pop_front());
         dec_busy = 1'b1;
         dec_rd   = -1;
      end
      bus.avail_DEC = dec_busy;
   endtask

   task automatic observe();
      if (bus.read_DEC) begin
         n_reads++;
         if (dec_busy && dec_rd < 0) dec_rd = cyc;
      end
      if (bus.start_ENC) begin
         sched_attempt(starts.size(), cyc);
         starts.push_back(cyc);
         enc_busy_until = cyc + t_busy;
      end
      if (bus.done) begin
         n_done++;
         done_cyc   = cyc;
         ret_at_end = int'(bus.retries);
      end
      if (bus.fail) begin
         n_fail++;
         fail_cyc   = cyc;
         ret_at_end = int'(bus.retries);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      drive();
      @(negedge clk);
      observe();
   endtask

   task automatic clear_rec();
      starts.delete();
      n_reads    = 0;
      n_done     = 0;
      n_fail     = 0;
      n_sched    = 0;
      done_cyc   = -1;
      fail_cyc   = -1;
      ret_at_end = -1;
   endtask

   task automatic idle(int n);
      bus.tx_valid = 1'b0;
      n_done = 0;
      n_fail = 0;
      for (int i = 0; i < n; i++) step();
      check("idle_pulse", n_done + n_fail, 0);
   endtask

   task automatic run_txn(logic [N_PKT-1:0] pkt, int gap, int lost,
                          int d, int busy, int njunk);
      int  acc;
      int  s0;
      int  n_st;
      int  budget;
      bit  ended;
      bit  success;
      t_pkt   = pkt;
      t_lost  = lost;
      t_d     = d;
      t_busy  = busy;
      t_njunk = njunk;
      clear_rec();
      bus.tx_data  = pkt;
      bus.tx_valid = 1'b1;
      acc = -1;
      for (int i = 0; i < 10 && acc < 0; i++) begin
         if (bus.tx_ready) acc = cyc;
         else step();
      end
      check("accept", acc >= 0, 1);
      if (acc < 0) return;
      enc_busy_until = acc + gap;
      step();
      bus.tx_valid = 1'b0;
      bus.tx_data  = N_PKT'($urandom);
      success = (lost <= int'(MAX_RETRY));
      budget  = int'((MAX_RETRY + 2) * TIMEOUT) + gap + 100;
      ended   = 1'b0;
      for (int i = 0; i < budget && !ended; i++) begin
         if (n_done + n_fail > 0) ended = 1'b1;
         else step();
      end
      check("end_seen", ended, 1);
      s0   = acc + 1 + gap;
      n_st = success ? lost + 1 : int'(MAX_RETRY) + 1;
      check("n_start", starts.size(), n_st);
      for (int k = 0; k < n_st && k < starts.size(); k++)
         check($sformatf("start%0d", k), starts[k],
               s0 + k * int'(TIMEOUT));
      if (success) begin
         check("done_cyc", done_cyc, s0 + lost * int'(TIMEOUT) + d + 1);
         check("n_fail", n_fail, 0);
         check("retries", ret_at_end, lost);
      end else begin
         check("fail_cyc", fail_cyc,
               s0 + int'((MAX_RETRY + 1) * TIMEOUT));
         check("n_done", n_done, 0);
         check("retries", ret_at_end, MAX_RETRY);
      end
      check("n_reads", n_reads, n_sched);
      check("tx_ready", bus.tx_ready, 1);
      check("data_ENC", bus.data_ENC, pkt);
   endtask

   task automatic reset_test();
      int acc;
      t_pkt   = 8'h42;
      t_lost  = 99;
      t_d     = 0;
      t_busy  = 20;
      t_njunk = 0;
      clear_rec();
      bus.tx_data  = 8'h42;
      bus.tx_valid = 1'b1;
      acc = -1;
      for (int i = 0; i < 10 && acc < 0; i++) begin
         if (bus.tx_ready) acc = cyc;
         else step();
      end
      check("rst_accept", acc >= 0, 1);
      step();
      bus.tx_valid = 1'b0;
      for (int i = 0; i < 100 && starts.size() == 0; i++) step();
      check("rst_started", starts.size(), 1);
      repeat (30) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_tx_ready", bus.tx_ready, 1);
      check("rst_done", bus.done, 0);
      check("rst_fail", bus.fail, 0);
      check("rst_retries", bus.retries, 0);
      check("rst_data_ENC", bus.data_ENC, 0);
      check("rst_start_ENC", bus.start_ENC, 0);
      n_done  = 0;
      n_fail  = 0;
      n_reads = 0;
      n_sched = 0;
      push_byte(cyc + 5, 8'hBD, 1'b0);
      repeat (60) step();
      check("rst_no_pulse", n_done + n_fail, 0);
      check("rst_drain", n_reads, n_sched);
   endtask

   initial begin
      int gap;
      int lost;
      int d;
      int sel;
      rst           = 1'b1;
      bus.tx_valid  = 1'b0;
      bus.tx_data   = '0;
      bus.avail_ENC = 1'b1;
      bus.avail_DEC = 1'b0;
      bus.data_DEC  = '0;
      bus.error_DEC = 1'b0;
      dec_busy      = 1'b0;
      dec_rd        = -1;
      enc_busy_until = -1;
      t_pkt   = '0;
      t_lost  = 99;
      t_d     = 0;
      t_busy  = 20;
      t_njunk = 0;
      clear_rec();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("init_tx_ready", bus.tx_ready, 1);
      check("init_done", bus.done, 0);
      check("init_fail", bus.fail, 0);
      check("init_retries", bus.retries, 0);
      check("init_start_ENC", bus.start_ENC, 0);
      check("init_read_DEC", bus.read_DEC, 0);
      check("init_data_ENC", bus.data_ENC, 0);
      rst = 1'b0;
      step();

      run_txn(8'h42, 0, 0, 300, 20, 0);
      idle(3);
      run_txn(8'h42, 0, 1, 200, 20, 0);
      idle(2);
      run_txn(8'h42, 0, int'(MAX_RETRY) + 1, 0, 20, 0);
      run_txn(8'h42, 0, 0, 300, 20, 2);
      idle(2);
      run_txn(8'h5A, 50, 0, 100, 20, 0);
      idle(2);
      reset_test();
      idle(2);

      for (int t = 0; t < 10; t++) begin
         gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 8));
         if ($urandom_range(0, 3) == 0) lost = int'(MAX_RETRY) + 1;
         else lost = int'($urandom_range(0, MAX_RETRY));
         sel = int'($urandom_range(0, 3));
         if (sel == 0) d = 1;
         else if (sel == 1) d = int'(TIMEOUT) - 1;
         else d = int'($urandom_range(2, TIMEOUT - 2));
         run_txn(N_PKT'($urandom), gap, lost, d,
                 int'($urandom_range(1, 100)), -1);
         if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 4)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/arq_controller.md
# arq_controller

Stop-and-wait retransmission controller that sequences one pulse-link Encoder/Decoder pair on behalf of a player. It accepts one N_PKT-bit packet from the application and launches it on the Encoder. It then waits for the peer's acknowledgement on the Decoder and retransmits on timeout. After MAX_RETRY retransmissions it reports failure. It sits between the player logic and the Encoder/Decoder, replacing ad-hoc start/read sequencing in each player.

## Interface
- N_PKT, 8, packet width in bits
- TIMEOUT, 1540, cycles from start_ENC pulse to retransmit; must be ≥ 2
- MAX_RETRY, 3, maximum retransmissions after the first send; ≥ 0
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- tx_data  in  N_PKT  packet to send, sampled on accept
- tx_valid  in  1  application has a packet
- tx_ready  out  1  controller idle; accept = tx_valid & tx_ready
- done  out  1  one-cycle pulse: acknowledgement received
- fail  out  1  one-cycle pulse: retries exhausted
- retries  out  $clog2(MAX_RETRY+1)  retransmissions used for current/last packet
- start_ENC  out  1  one-cycle Encoder start
- data_ENC  out  N_PKT  packet to Encoder, held stable from accept until done/fail
- avail_ENC  in  1  Encoder idle and able to take start
- data_DEC  in  N_PKT  Decoder output byte
- avail_DEC  in  1  Decoder has an unread byte
- error_DEC  in  1  Decoder byte is corrupt; qualified by avail_DEC
- read_DEC  out  1  one-cycle pulse consuming the Decoder byte

## Operation
- States: IDLE, SEND, WAIT_ACK. done and fail are pulses emitted on the exit edge from WAIT_ACK to IDLE.
- A valid acknowledgement is avail_DEC=1, error_DEC=0 and data_DEC == ~pkt, where pkt is the registered packet.
- IDLE:
  - tx_ready=1.
  - On accept, register tx_data into pkt and drive it on data_ENC.
  - Clear retries and go to SEND.
- SEND:
  - start_ENC = avail_ENC, combinational.
  - On the cycle start_ENC=1, clear the timer and go to WAIT_ACK.
  - While avail_ENC=0, wait indefinitely; the timer is not running.
- WAIT_ACK:
  - The timer increments every cycle.
  - Valid acknowledgement → done pulse, go to IDLE.
  - Timer == TIMEOUT-1 with no valid acknowledgement:
    - If retries < MAX_RETRY → retries+1, go to SEND.
    - Otherwise → fail pulse, go to IDLE; retries stays at MAX_RETRY.
- Decoder draining:
  - In every state, read_DEC = avail_DEC & ~read_q, where read_q is read_DEC registered. This gives at most one read per byte, even though avail_DEC falls a cycle late.
  - Bytes that are corrupt, mismatched, or arrive in IDLE or SEND are consumed and ignored.
- Width rules:
  - Timer width is $clog2(TIMEOUT).
  - Comparison is equality only; no wrap is reachable.
  - retries saturates at MAX_RETRY.

## Timing
- Reset values:
  - state IDLE, tx_ready=1 (it is combinational from state).
  - done=0, fail=0, retries=0, start_ENC=0, read_DEC=0.
  - data_ENC=0, timer=0, read_q=0.
- Reset mid-operation: return to IDLE on the next edge and abandon the packet. No done or fail pulse.
- Accept at edge T: data_ENC valid after T; state SEND in cycle T+1. start_ENC is high in T+1 if avail_ENC=1.
- Timeout: with start_ENC in cycle S and no acknowledgement, the state is SEND again in cycle S+TIMEOUT. A retransmit start_ENC is therefore possible in S+TIMEOUT when avail_ENC=1.
- Simultaneous valid acknowledgement and timer == TIMEOUT-1: the acknowledgement wins, giving done with no retry.
- done and fail are registered: high in the first IDLE cycle for exactly one cycle. tx_ready is also 1 in that cycle, so back-to-back accept is allowed.
- The acknowledgement byte is read in the same cycle it is recognised.

## Structure
- Package arq_pkg holds:
  - state enum arq_state_e {IDLE, SEND, WAIT_ACK}
  - function ack_of(pkt), which returns ~pkt; the peer responder uses the same function.
- Sub-module arq_timer: a parameterised TIMEOUT counter with clear, enable and expire outputs. It is reusable by the responder side.
- All other logic stays in one always_ff plus one always_comb.

## Test plan
- Clean round trip: tx_data=8'h42 accepted, peer echoes 8'hBD after 300 cycles. Required: one start_ENC, one read_DEC, done one cycle later, retries=0.
- Single loss: first send gets no echo; echo 8'hBD arrives 200 cycles after the retransmit. Required: start_ENC at S and S+1540, done pulse, retries=1.
- Exhaustion with MAX_RETRY=3 and no echo. Required: four start_ENC pulses spaced 1540 cycles, fail pulse, retries=3, tx_ready=1.
- Wrong byte: decoder delivers error_DEC=1, then 8'h42, then 8'hBD. Required: three read_DEC pulses, done only after 8'hBD.
- avail_ENC held low 50 cycles after accept. Required: no start_ENC and no timer advance; start_ENC in the first cycle avail_ENC=1.
- rst pulsed while in WAIT_ACK. Required: next cycle IDLE, tx_ready=1, no done or fail; a later 8'hBD is drained without done.
